// File: rtl/sd_types.sv
`default_nettype none
// ============================================================================
// Module   : sd_types (package)
// Purpose  : Basic byte type shared across the SD datapath.
// Revision : 1.0
// ============================================================================
package sd_types;
  typedef logic [7:0] sdBYTE_t;
endpackage
`default_nettype wire

// File: rtl/sdcmd_types.sv
`default_nettype none
// ============================================================================
// Module   : sdcmd_types (package)
// Purpose  : Sequencer states, frame constants and the bytewise CRC7 update.
// Revision : 1.0
// ============================================================================
package sdcmd_types;
  import sd_types::*;

  localparam sdBYTE_t SD_FILL   = 8'hFF;
  localparam int      FRAME_LEN = 6;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_CSL   = 4'd1,
    ST_PRE   = 4'd2,
    ST_WPRE  = 4'd3,
    ST_SEND  = 4'd4,
    ST_WSEND = 4'd5,
    ST_POLL  = 4'd6,
    ST_WPOLL = 4'd7,
    ST_END   = 4'd8,
    ST_CSH   = 4'd9,
    ST_POST  = 4'd10,
    ST_WPOST = 4'd11,
    ST_FIN   = 4'd12
  } seqState_t;

  // MSB-first shift through x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_byte(input logic [6:0] crc, input sdBYTE_t data);
    logic [6:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction
endpackage
`default_nettype wire

// File: rtl/sdspi_types.sv
`default_nettype none
// ============================================================================
// Module   : sdspi_types (package)
// Purpose  : Operation codes accepted by the SD SPI byte interface.
// Revision : 1.0
// ============================================================================
package sdspi_types;
  typedef enum logic [1:0] {
    spiNOP = 2'd0,
    spiCSL = 2'd1,
    spiCSH = 2'd2,
    spiTR  = 2'd3
  } spiOP_t;
endpackage
`default_nettype wire

// File: rtl/sd_cmd_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : sd_cmd_seq_if
// Purpose  : Controller command handshake plus SPI byte-interface signals.
// Revision : 1.0
// ============================================================================
interface sd_cmd_seq_if;
  import sd_types::*;
  import sdspi_types::*;

  logic        cmdSTART;
  logic [5:0]  cmdIDX;
  logic [31:0] cmdARG;
  logic        cmdKEEPCS;
  logic        cmdBUSY;
  logic        cmdDONE;
  sdBYTE_t     cmdR1;
  logic        cmdTIMEOUT;
  spiOP_t      spiOP;
  sdBYTE_t     spiTXD;
  sdBYTE_t     spiRXD;
  logic        spiDONE;

  modport master (
    output cmdSTART, cmdIDX, cmdARG, cmdKEEPCS, spiRXD, spiDONE,
    input  cmdBUSY, cmdDONE, cmdR1, cmdTIMEOUT, spiOP, spiTXD
  );

  modport slave (
    input  cmdSTART, cmdIDX, cmdARG, cmdKEEPCS, spiRXD, spiDONE,
    output cmdBUSY, cmdDONE, cmdR1, cmdTIMEOUT, spiOP, spiTXD
  );
endinterface
`default_nettype wire

// File: rtl/sd_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : sd_cmd_seq
// Purpose  : Frames an SD command with CRC7, polls for R1, reports timeout.
// Revision : 1.0
// ============================================================================
module sd_cmd_seq
  import sd_types::*;
  import sdspi_types::*;
  import sdcmd_types::*;
#(
  parameter int MAX_POLL = 8
) (
  input  logic         clk,
  input  logic         rst,
  sd_cmd_seq_if.slave  bus
);

  localparam int             c_PCW       = $clog2(MAX_POLL + 1);
  localparam logic [c_PCW-1:0] c_LAST_POLL = c_PCW'(MAX_POLL - 1);
  localparam logic [2:0]     c_LAST_BYTE = 3'(FRAME_LEN - 1);

  seqState_t        r_state,   w_stateNext;
  logic [5:0]       r_cmdIdx,  w_cmdIdxNext;
  logic [31:0]      r_arg,     w_argNext;
  logic             r_keepCs,  w_keepCsNext;
  logic [2:0]       r_byteIdx, w_byteIdxNext;
  logic [6:0]       r_crc,     w_crcNext;
  logic [c_PCW-1:0] r_pollCnt, w_pollCntNext;
  logic             r_busy,    w_busyNext;
  logic             r_done,    w_doneNext;
  sdBYTE_t          r_r1,      w_r1Next;
  logic             r_timeout, w_timeoutNext;
  spiOP_t           r_op,      w_opNext;
  sdBYTE_t          r_txd,     w_txdNext;

  logic [2:0]       w_frameSel;
  sdBYTE_t          w_frameByte;

  // Byte about to be loaded: byte 0 leaving WPRE, otherwise the next index.
  assign w_frameSel = (r_state == ST_WPRE) ? 3'd0 : r_byteIdx + 3'd1;

  always_comb begin
    w_frameByte = SD_FILL;
    case (w_frameSel)
      3'd0:    w_frameByte = {2'b01, r_cmdIdx};
      3'd1:    w_frameByte = r_arg[31:24];
      3'd2:    w_frameByte = r_arg[23:16];
      3'd3:    w_frameByte = r_arg[15:8];
      3'd4:    w_frameByte = r_arg[7:0];
      3'd5:    w_frameByte = {r_crc, 1'b1};
      default: w_frameByte = SD_FILL;
    endcase
  end

  always_comb begin
    w_stateNext   = r_state;
    w_cmdIdxNext  = r_cmdIdx;
    w_argNext     = r_arg;
    w_keepCsNext  = r_keepCs;
    w_byteIdxNext = r_byteIdx;
    w_crcNext     = r_crc;
    w_pollCntNext = r_pollCnt;
    w_busyNext    = r_busy;
    w_doneNext    = 1'b0;
    w_r1Next      = r_r1;
    w_timeoutNext = r_timeout;
    w_opNext      = spiNOP;
    w_txdNext     = r_txd;

    case (r_state)
      ST_IDLE: begin
        if (bus.cmdSTART) begin
          w_cmdIdxNext  = bus.cmdIDX;
          w_argNext     = bus.cmdARG;
          w_keepCsNext  = bus.cmdKEEPCS;
          w_crcNext     = 7'd0;
          w_pollCntNext = '0;
          w_timeoutNext = 1'b0;
          w_busyNext    = 1'b1;
          w_opNext      = spiCSL;
          w_stateNext   = ST_CSL;
        end
      end
      ST_CSL: w_stateNext = ST_PRE;
      ST_PRE: begin
        w_opNext    = spiTR;
        w_txdNext   = SD_FILL;
        w_stateNext = ST_WPRE;
      end
      ST_WPRE: begin
        if (bus.spiDONE) begin
          w_byteIdxNext = 3'd0;
          w_opNext      = spiTR;
          w_txdNext     = w_frameByte;
          w_crcNext     = crc7_byte(r_crc, w_frameByte);
          w_stateNext   = ST_SEND;
        end
      end
      ST_SEND: w_stateNext = ST_WSEND;
      ST_WSEND: begin
        if (bus.spiDONE) begin
          w_opNext  = spiTR;
          if (r_byteIdx == c_LAST_BYTE) begin
            w_txdNext     = SD_FILL;
            w_pollCntNext = '0;
            w_stateNext   = ST_POLL;
          end else begin
            w_byteIdxNext = w_frameSel;
            w_txdNext     = w_frameByte;
            // The CRC byte itself is not folded into the CRC.
            if (w_frameSel != c_LAST_BYTE) w_crcNext = crc7_byte(r_crc, w_frameByte);
            w_stateNext   = ST_SEND;
          end
        end
      end
      ST_POLL: w_stateNext = ST_WPOLL;
      ST_WPOLL: begin
        if (bus.spiDONE) begin
          if (!bus.spiRXD[7]) begin
            w_r1Next    = bus.spiRXD;
            w_stateNext = ST_END;
          end else if (r_pollCnt == c_LAST_POLL) begin
            w_r1Next      = 8'hFF;
            w_timeoutNext = 1'b1;
            w_opNext      = spiCSH;
            w_stateNext   = ST_CSH;
          end else begin
            w_pollCntNext = r_pollCnt + 1'b1;
            w_opNext      = spiTR;
            w_txdNext     = SD_FILL;
            w_stateNext   = ST_POLL;
          end
        end
      end
      ST_END: begin
        if (r_keepCs && !r_timeout) begin
          w_doneNext  = 1'b1;
          w_stateNext = ST_FIN;
        end else begin
          w_opNext    = spiCSH;
          w_stateNext = ST_CSH;
        end
      end
      ST_CSH: w_stateNext = ST_POST;
      ST_POST: begin
        w_opNext    = spiTR;
        w_txdNext   = SD_FILL;
        w_stateNext = ST_WPOST;
      end
      ST_WPOST: begin
        if (bus.spiDONE) begin
          w_doneNext  = 1'b1;
          w_stateNext = ST_FIN;
        end
      end
      ST_FIN: begin
        w_busyNext  = 1'b0;
        w_stateNext = ST_IDLE;
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cmdIdx  <= 6'd0;
      r_arg     <= 32'd0;
      r_keepCs  <= 1'b0;
      r_byteIdx <= 3'd0;
      r_crc     <= 7'd0;
      r_pollCnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_r1      <= 8'hFF;
      r_timeout <= 1'b0;
      r_op      <= spiNOP;
      r_txd     <= SD_FILL;
    end else begin
      r_state   <= w_stateNext;
      r_cmdIdx  <= w_cmdIdxNext;
      r_arg     <= w_argNext;
      r_keepCs  <= w_keepCsNext;
      r_byteIdx <= w_byteIdxNext;
      r_crc     <= w_crcNext;
      r_pollCnt <= w_pollCntNext;
      r_busy    <= w_busyNext;
      r_done    <= w_doneNext;
      r_r1      <= w_r1Next;
      r_timeout <= w_timeoutNext;
      r_op      <= w_opNext;
      r_txd     <= w_txdNext;
    end
  end

  assign bus.cmdBUSY    = r_busy;
  assign bus.cmdDONE    = r_done;
  assign bus.cmdR1      = r_r1;
  assign bus.cmdTIMEOUT = r_timeout;
  assign bus.spiOP      = r_op;
  assign bus.spiTXD     = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_cmd_seq
// Purpose  : Randomized bench with an SPI/card model and a frame-level reference.
// Revision : 1.0
// ============================================================================
module tb_sd_cmd_seq;
  import sd_types::*;
  import sdspi_types::*;

  localparam int MAX_POLL = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  sd_cmd_seq_if bus();

  sd_cmd_seq #(.MAX_POLL(MAX_POLL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- SPI interface + card model ----------------
  int          cfgReply = -1;   // poll index at which the card answers, -1 = never
  sdBYTE_t     cfgR1    = 8'h01;
  int          xferIdx  = 0;
  int          pend     = 0;
  logic        csLow    = 1'b0;
  int          gapErr   = 0;
  int          lastDoneCyc = 0;
  logic        afterDone = 1'b0;
  logic [9:0]  logQ[$];
  int          logCyc[$];

  function automatic sdBYTE_t card_byte(input int k);
    if (k < 7) return 8'hFF;
    if ((k - 7) == cfgReply) return cfgR1;
    return 8'h80 | 8'($urandom_range(0, 127));
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      pend        = 0;
      bus.spiDONE = 1'b0;
      csLow       = 1'b0;
      afterDone   = 1'b0;
    end else begin
      bus.spiDONE = 1'b0;
      if (bus.spiOP != spiNOP) begin
        logQ.push_back({bus.spiOP, (bus.spiOP == spiTR) ? bus.spiTXD : 8'h00});
        logCyc.push_back(cyc);
      end
      if (bus.spiOP == spiCSL) begin
        csLow = 1'b1; xferIdx = 0; afterDone = 1'b0;
      end else if (bus.spiOP == spiCSH) begin
        csLow = 1'b0; afterDone = 1'b0;
      end else if (bus.spiOP == spiTR) begin
        if (afterDone && cyc != lastDoneCyc + 1) gapErr++;
        if (pend != 0) gapErr++;
        afterDone = 1'b0;
        pend = $urandom_range(1, 4);
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.spiDONE = 1'b1;
          bus.spiRXD  = card_byte(xferIdx);
          xferIdx++;
          lastDoneCyc = cyc;
          afterDone   = 1'b1;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] crc_ref(input logic [39:0] msg);
    logic [46:0] v;
    v = {msg, 7'd0};
    for (int i = 46; i >= 7; i--)
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    return v[6:0];
  endfunction

  task automatic verify_cmd(input string name, input logic [5:0] idx, input logic [31:0] arg,
                            input logic keep, input int reply, input logic [7:0] r1, input int startCyc);
    logic [9:0]  exp[$];
    logic [39:0] msg;
    logic [47:0] frame;
    int          polls;
    logic        to;
    int          bad;
    msg   = {2'b01, idx, arg};
    frame = {msg, crc_ref(msg), 1'b1};
    to    = !(reply >= 0 && reply < MAX_POLL);
    polls = to ? MAX_POLL : reply + 1;
    exp.push_back({spiCSL, 8'h00});
    exp.push_back({spiTR, 8'hFF});
    for (int i = 0; i < 6; i++) exp.push_back({spiTR, frame[47 - 8*i -: 8]});
    for (int i = 0; i < polls; i++) exp.push_back({spiTR, 8'hFF});
    if (!keep || to) begin
      exp.push_back({spiCSH, 8'h00});
      exp.push_back({spiTR, 8'hFF});
    end

    vectors++;
    if (bus.cmdR1 !== (to ? 8'hFF : r1)) begin
      errors++; $display("FAIL %s r1: got %h expected %h", name, bus.cmdR1, to ? 8'hFF : r1);
    end
    vectors++;
    if (bus.cmdTIMEOUT !== to) begin
      errors++; $display("FAIL %s timeout: got %b expected %b", name, bus.cmdTIMEOUT, to);
    end
    vectors++;
    bad = (logQ.size() != exp.size()) ? 0 : -1;
    if (bad < 0)
      for (int i = 0; i < exp.size(); i++) if (bad < 0 && logQ[i] !== exp[i]) bad = i;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s op log: %0d ops, expected %0d, first diff at %0d got %h expected %h",
               name, logQ.size(), exp.size(), bad,
               (bad < logQ.size()) ? logQ[bad] : 10'h3FF, (bad < exp.size()) ? exp[bad] : 10'h3FF);
    end
    vectors++;
    if (logCyc.size() == 0 || logCyc[0] != startCyc + 1) begin
      errors++; $display("FAIL %s csl cycle: got %0d expected %0d", name,
                         (logCyc.size() == 0) ? -1 : logCyc[0], startCyc + 1);
    end
    vectors++;
    if (gapErr != 0) begin
      errors++; $display("FAIL %s transfer gap: %0d violations expected 0", name, gapErr);
    end
    vectors++;
    if (csLow !== (keep && !to)) begin
      errors++; $display("FAIL %s cs low at end: got %b expected %b", name, csLow, keep && !to);
    end
    vectors++;
    if (bus.cmdBUSY !== 1'b1) begin
      errors++; $display("FAIL %s busy during done: got %b expected 1", name, bus.cmdBUSY);
    end
  endtask

  task automatic set_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic keep,
                         input int reply, input logic [7:0] r1);
    cfgReply = reply; cfgR1 = r1;
    bus.cmdIDX = idx; bus.cmdARG = arg; bus.cmdKEEPCS = keep;
    logQ.delete(); logCyc.delete(); gapErr = 0;
  endtask

  task automatic wait_done(input string name, output logic ok);
    int n = 0;
    while (bus.cmdDONE !== 1'b1 && n < 600) begin @(negedge clk); n++; end
    ok = (bus.cmdDONE === 1'b1);
    vectors++;
    if (!ok) begin errors++; $display("FAIL %s done: got no cmdDONE expected pulse", name); end
  endtask

  task automatic do_command(input string name, input logic [5:0] idx, input logic [31:0] arg,
                            input logic keep, input int reply, input logic [7:0] r1);
    int   startCyc;
    logic ok;
    set_cmd(idx, arg, keep, reply, r1);
    bus.cmdSTART = 1'b1;
    startCyc = cyc;
    @(negedge clk);
    bus.cmdSTART = 1'b0;
    vectors++;
    if (bus.cmdBUSY !== 1'b1) begin errors++; $display("FAIL %s busy after start: got %b expected 1", name, bus.cmdBUSY); end
    wait_done(name, ok);
    if (ok) begin
      verify_cmd(name, idx, arg, keep, reply, r1, startCyc);
      @(negedge clk);
      vectors++;
      if (bus.cmdDONE !== 1'b0 || bus.cmdBUSY !== 1'b0) begin
        errors++; $display("FAIL %s after done: done=%b busy=%b expected 0 0", name, bus.cmdDONE, bus.cmdBUSY);
      end
    end
  endtask

  function automatic int count_op(input spiOP_t op);
    int n = 0;
    foreach (logQ[i]) if (logQ[i][9:8] == op) n++;
    return n;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.cmdBUSY !== 1'b0 || bus.cmdDONE !== 1'b0 || bus.cmdR1 !== 8'hFF || bus.cmdTIMEOUT !== 1'b0 ||
        bus.spiOP !== spiNOP || bus.spiTXD !== 8'hFF) begin
      errors++;
      $display("FAIL reset values: busy=%b done=%b r1=%h to=%b op=%0d txd=%h expected 0 0 ff 0 0 ff",
               bus.cmdBUSY, bus.cmdDONE, bus.cmdR1, bus.cmdTIMEOUT, bus.spiOP, bus.spiTXD);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cmd0();
    do_command("cmd0", 6'd0, 32'd0, 1'b0, 1, 8'h01);
    vectors++;
    if (logQ.size() < 8 || logQ[7][7:0] !== 8'h95) begin
      errors++; $display("FAIL cmd0 crc byte: got %h expected 95", (logQ.size() < 8) ? 8'h00 : logQ[7][7:0]);
    end
    vectors++;
    if (count_op(spiTR) != 10) begin errors++; $display("FAIL cmd0 transfers: got %0d expected 10", count_op(spiTR)); end
  endtask

  task automatic test_cmd8();
    do_command("cmd8", 6'd8, 32'h000001AA, 1'b0, 0, 8'h01);
    vectors++;
    if (logQ.size() < 8 || logQ[6][7:0] !== 8'hAA || logQ[7][7:0] !== 8'h87) begin
      errors++; $display("FAIL cmd8 tail bytes: got %h %h expected aa 87",
                         (logQ.size() < 8) ? 8'h00 : logQ[6][7:0], (logQ.size() < 8) ? 8'h00 : logQ[7][7:0]);
    end
  endtask

  task automatic test_keepcs();
    do_command("cmd17 keepcs", 6'd17, $urandom, 1'b1, 0, 8'h00);
    vectors++;
    if (count_op(spiTR) != 8 || count_op(spiCSH) != 0) begin
      errors++; $display("FAIL keepcs ops: got %0d transfers %0d csh expected 8 0", count_op(spiTR), count_op(spiCSH));
    end
  endtask

  task automatic test_timeout();
    do_command("timeout", 6'd55, $urandom, 1'b1, -1, 8'h00);
    vectors++;
    if (count_op(spiTR) != 1 + 6 + MAX_POLL + 1 || count_op(spiCSH) != 1) begin
      errors++; $display("FAIL timeout ops: got %0d transfers %0d csh expected %0d 1",
                         count_op(spiTR), count_op(spiCSH), 1 + 6 + MAX_POLL + 1);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      int r;
      r = $urandom_range(0, MAX_POLL);
      do_command("random", 6'($urandom), $urandom, 1'($urandom), (r == MAX_POLL) ? -1 : r,
                 8'($urandom_range(0, 127)));
    end
  endtask

  task automatic test_busy_ignore();
    logic [5:0]  idx;
    logic [31:0] arg;
    int          startCyc, sz;
    logic        ok;
    idx = 6'($urandom); arg = $urandom;
    set_cmd(idx, arg, 1'b0, 2, 8'h05);
    bus.cmdSTART = 1'b1; startCyc = cyc;
    @(negedge clk);
    bus.cmdSTART = 1'b0;
    repeat (10) @(negedge clk);
    bus.cmdIDX = ~idx; bus.cmdARG = ~arg; bus.cmdSTART = 1'b1;
    @(negedge clk);
    bus.cmdSTART = 1'b0;
    wait_done("busy pulse", ok);
    if (ok) begin
      verify_cmd("busy pulse", idx, arg, 1'b0, 2, 8'h05, startCyc);
      sz = logQ.size();
      repeat (6) @(negedge clk);
      vectors++;
      if (bus.cmdBUSY !== 1'b0 || logQ.size() != sz) begin
        errors++; $display("FAIL busy pulse queued: busy=%b new ops=%0d expected 0 0", bus.cmdBUSY, logQ.size() - sz);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] argB;
    int          startA, startB, doneCyc;
    logic        ok;
    argB = $urandom;
    set_cmd(6'd9, 32'h12345678, 1'b0, 0, 8'h00);
    bus.cmdSTART = 1'b1; startA = cyc;
    @(negedge clk);
    wait_done("b2b first", ok);
    if (ok) begin
      verify_cmd("b2b first", 6'd9, 32'h12345678, 1'b0, 0, 8'h00, startA);
      doneCyc = cyc;
      set_cmd(6'd13, argB, 1'b1, 3, 8'h02);
      @(negedge clk);
      startB = cyc;
      vectors++;
      if (bus.cmdBUSY !== 1'b0 || startB != doneCyc + 1) begin
        errors++; $display("FAIL b2b idle gap: busy=%b expected 0", bus.cmdBUSY);
      end
      @(negedge clk);
      bus.cmdSTART = 1'b0;
      wait_done("b2b second", ok);
      if (ok) verify_cmd("b2b second", 6'd13, argB, 1'b1, 3, 8'h02, startB);
    end
    bus.cmdSTART = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    set_cmd(6'd24, $urandom, 1'b0, 0, 8'h00);
    bus.cmdSTART = 1'b1;
    @(negedge clk);
    bus.cmdSTART = 1'b0;
    while (logQ.size() < 6 && n < 300) begin @(negedge clk); n++; end
    vectors++;
    if (logQ.size() < 6) begin errors++; $display("FAIL reset mid reach byte3: got %0d ops expected 6", logQ.size()); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.cmdBUSY !== 1'b0 || bus.cmdDONE !== 1'b0 || bus.cmdR1 !== 8'hFF || bus.cmdTIMEOUT !== 1'b0 ||
        bus.spiOP !== spiNOP || bus.spiTXD !== 8'hFF) begin
      errors++;
      $display("FAIL reset mid values: busy=%b done=%b r1=%h to=%b op=%0d txd=%h expected 0 0 ff 0 0 ff",
               bus.cmdBUSY, bus.cmdDONE, bus.cmdR1, bus.cmdTIMEOUT, bus.spiOP, bus.spiTXD);
    end
    rst = 1'b0;
    @(negedge clk);
    do_command("cmd0 after reset", 6'd0, 32'd0, 1'b0, 1, 8'h01);
  endtask

  initial begin
    bus.cmdSTART = 1'b0; bus.cmdIDX = 6'd0; bus.cmdARG = 32'd0; bus.cmdKEEPCS = 1'b0;
    bus.spiRXD = 8'hFF; bus.spiDONE = 1'b0;
    test_reset();
    test_cmd0();
    test_cmd8();
    test_keepcs();
    test_timeout();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
`default_nettype wire
